disp_src_sequencer: RTL and testbench

- Parametrised, registered successor of the display-source selector.
- Selects one of NUM_CH digit groups (time, alarm, stopwatch, ...) for the NUM_DIG-digit 7-segment driver.
- Adds an override path (minigame), blanked switch-over between sources, and per-digit blink for edit mode.
- Sits between the timekeeping/game blocks and the 7-segment decoder/scanner.

---
 rtl/disp_pkg.sv | 15 +
 rtl/blink_timer.sv | 31 +++
 rtl/disp_src_sequencer.sv | 128 ++++++++++++
 tb/tb_disp_src_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-source sequencer.
package disp_pkg;

  typedef enum logic [1:0] {SHOW, BLANK, OVR} state_t;

  localparam int unsigned DIG_W_DEF = 4;
  localparam logic [DIG_W_DEF-1:0] DIG_BLANK = '0;

  // LSB position of digit `dig` of channel `ch` on the packed source bus.
  function automatic int unsigned field_lsb(input int unsigned ch, input int unsigned dig,
                                            input int unsigned num_dig, input int unsigned dig_w);
    return (ch * num_dig + dig) * dig_w;
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Free-running blink phase generator; restart clears to the start of a visible half-period.
module blink_timer #(
  parameter int unsigned BLINK_HALF = 25000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic phase
);

  localparam int unsigned W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [W-1:0] LAST = W'(BLINK_HALF - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (restart) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/disp_src_sequencer.sv
// Registered display-source selector with override path, blanked switch-over and edit blink.
module disp_src_sequencer
  import disp_pkg::*;
#(
  parameter int unsigned NUM_CH       = 3,
  parameter int unsigned NUM_DIG      = 4,
  parameter int unsigned DIG_W        = DIG_W_DEF,
  parameter int unsigned BLANK_CYCLES = 4,
  parameter int unsigned BLINK_HALF   = 25000000,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [NUM_CH-1:0]                 SEL_ONEHOT,
  input  logic [NUM_CH*NUM_DIG*DIG_W-1:0]   CH_DATA,
  input  logic                              OVR_EN,
  input  logic [NUM_DIG*DIG_W-1:0]          OVR_DATA,
  input  logic [NUM_DIG-1:0]                EDIT_MASK,
  output logic [NUM_DIG*DIG_W-1:0]          DISP_DATA,
  output logic [NUM_DIG-1:0]                DISP_BLANK,
  output logic [CH_W-1:0]                   ACTIVE_CH,
  output logic                              SWITCHING
);

  localparam int unsigned GRP_W  = NUM_DIG * DIG_W;
  localparam int unsigned CNT_W  = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned RELOAD = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CH_W-1:0]    target;
  logic               found;
  logic [GRP_W-1:0]   act_grp;
  logic               edit_nz_q;
  logic               blink_restart;
  logic               blink_phase;

  // Lowest-index set bit wins; no bit set falls back to channel 0.
  always_comb begin
    target = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (SEL_ONEHOT[i] && !found) begin
        target = CH_W'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    act_grp = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (ACTIVE_CH == CH_W'(c)) act_grp = CH_DATA[field_lsb(c, 0, NUM_DIG, DIG_W) +: GRP_W];
    end
  end

  always_comb blink_restart = (|EDIT_MASK) & ~edit_nz_q;

  blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .CLK     (CLK),
    .RST     (RST),
    .restart (blink_restart),
    .phase   (blink_phase)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= SHOW;
      cnt        <= '0;
      ACTIVE_CH  <= '0;
      DISP_DATA  <= {NUM_DIG{DIG_W'(DIG_BLANK)}};
      DISP_BLANK <= '0;
      SWITCHING  <= 1'b0;
      edit_nz_q  <= 1'b0;
    end else begin
      edit_nz_q <= |EDIT_MASK;
      if (OVR_EN) begin
        state      <= OVR;
        DISP_DATA  <= OVR_DATA;
        DISP_BLANK <= '0;
        SWITCHING  <= 1'b0;
      end else begin
        case (state)
          SHOW: begin
            DISP_DATA  <= act_grp;
            DISP_BLANK <= EDIT_MASK & {NUM_DIG{blink_phase}};
            SWITCHING  <= 1'b0;
            if (target != ACTIVE_CH) begin
              ACTIVE_CH <= target;
              if (BLANK_CYCLES > 0) begin
                state <= BLANK;
                cnt   <= CNT_W'(RELOAD);
              end
            end
          end
          BLANK: begin
            DISP_DATA  <= act_grp;
            DISP_BLANK <= '1;
            SWITCHING  <= 1'b1;
            // A retarget restarts the dark window even on its final cycle.
            if (target != ACTIVE_CH) begin
              ACTIVE_CH <= target;
              cnt       <= CNT_W'(RELOAD);
            end else if (cnt == '0) begin
              state <= SHOW;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          OVR: begin
            DISP_DATA  <= OVR_DATA;
            DISP_BLANK <= '0;
            SWITCHING  <= 1'b0;
            ACTIVE_CH  <= target;
            if (BLANK_CYCLES > 0) begin
              state <= BLANK;
              cnt   <= CNT_W'(RELOAD);
            end else begin
              state <= SHOW;
            end
          end
          default: state <= SHOW;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_disp_src_sequencer.sv
// Bench for disp_src_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_disp_src_sequencer;

  localparam int BC = 4;
  localparam int BH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  sel = '0;
  logic [47:0] ch_data;
  logic        ovr_en = 1'b0;
  logic [15:0] ovr_data = 16'h0003;
  logic [3:0]  edit = '0;
  logic [15:0] disp_data;
  logic [3:0]  disp_blank;
  logic [1:0]  active_ch;
  logic        switching;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  disp_src_sequencer #(
    .NUM_CH(3), .NUM_DIG(4), .DIG_W(4), .BLANK_CYCLES(BC), .BLINK_HALF(BH)
  ) dut (
    .CLK(clk), .RST(rst), .SEL_ONEHOT(sel), .CH_DATA(ch_data), .OVR_EN(ovr_en),
    .OVR_DATA(ovr_data), .EDIT_MASK(edit), .DISP_DATA(disp_data), .DISP_BLANK(disp_blank),
    .ACTIVE_CH(active_ch), .SWITCHING(switching)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic int low_tgt(input logic [2:0] s);
    for (int i = 0; i < 3; i++) if (s[i]) return i;
    return 0;
  endfunction

  // Behavioural model: tracks the shown source, remaining dark outputs, override mode and
  // blink time since the last (re)start.
  logic [15:0] e_data;
  logic [3:0]  e_blank;
  logic [1:0]  e_act;
  logic        e_sw;
  int          m_act, m_dark, blink_t;
  bit          m_ovr, prev_nz;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_data = '0; e_blank = '0; e_act = '0; e_sw = 1'b0;
      m_act = 0; m_dark = 0; m_ovr = 1'b0; blink_t = 0; prev_nz = 1'b0;
    end else begin
      int tgt;
      bit ph, restart;
      tgt     = low_tgt(sel);
      ph      = ((blink_t / BH) % 2) == 1;
      restart = (edit != 0) && !prev_nz;
      prev_nz = (edit != 0);
      blink_t = restart ? 0 : blink_t + 1;
      if (ovr_en) begin
        e_data = ovr_data; e_blank = '0; e_sw = 1'b0; m_ovr = 1'b1;
      end else if (m_ovr) begin
        e_data = ovr_data; e_blank = '0; e_sw = 1'b0; m_ovr = 1'b0;
        m_act = tgt; m_dark = BC;
      end else if (m_dark > 0) begin
        e_data = ch_data[m_act*16 +: 16]; e_blank = 4'hF; e_sw = 1'b1;
        m_dark--;
        if (tgt != m_act) begin m_act = tgt; m_dark = BC; end
      end else begin
        e_data = ch_data[m_act*16 +: 16]; e_blank = ph ? edit : 4'h0; e_sw = 1'b0;
        if (tgt != m_act) begin m_act = tgt; m_dark = BC; end
      end
      e_act = 2'(m_act);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_data",   32'(disp_data),  32'(e_data));
      chk("model_blank",  32'(disp_blank), 32'(e_blank));
      chk("model_active", 32'(active_ch),  32'(e_act));
      chk("model_switch", 32'(switching),  32'(e_sw));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive dark+switching output cycles, bounded.
  task automatic count_dark(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (switching && disp_blank == 4'hF) n++;
      else if (n > 0) break;
    end
  endtask

  initial begin
    int n;
    ch_data = {16'h0559, 16'h5678, 16'h1234};
    #1 rst = 1'b1;
    chk_en = 1'b1;
    step(); step();
    chk("rst_data", 32'(disp_data), 32'h0);
    chk("rst_active", 32'(active_ch), 32'h0);
    chk("rst_switch", 32'(switching), 32'h0);
    #1 rst = 1'b0;
    step();
    chk("boot_data", 32'(disp_data), 32'h1234);
    chk("boot_active", 32'(active_ch), 32'h0);
    chk("boot_blank", 32'(disp_blank), 32'h0);

    sel = 3'b001; step();
    sel = 3'b100; step();
    chk("sw2_active", 32'(active_ch), 32'h2);
    count_dark(n);
    chk("sw2_dark_len", 32'(n), 32'd4);
    chk("sw2_data", 32'(disp_data), 32'h0559);
    chk("sw2_blank", 32'(disp_blank), 32'h0);

    sel = 3'b001; step();
    step();
    step();
    sel = 3'b110; step();
    chk("retarget_active", 32'(active_ch), 32'h1);
    count_dark(n);
    chk("retarget_dark_len", 32'(n), 32'd4);
    chk("retarget_data", 32'(disp_data), 32'h5678);

    sel = 3'b001; step();
    chk("ovr_pre_active", 32'(active_ch), 32'h0);
    step();
    chk("ovr_pre_switch", 32'(switching), 32'h1);
    ovr_en = 1'b1; step();
    chk("ovr_data", 32'(disp_data), 32'h0003);
    chk("ovr_blank", 32'(disp_blank), 32'h0);
    chk("ovr_switch", 32'(switching), 32'h0);
    step();
    ovr_en = 1'b0;
    count_dark(n);
    chk("ovr_exit_dark_len", 32'(n), 32'd4);
    chk("ovr_exit_data", 32'(disp_data), 32'h1234);

    edit = 4'b1100; step();
    for (int i = 0; i < 32; i++) begin
      step();
      chk("blink_pattern", 32'(disp_blank), ((i / BH) % 2) ? 32'hC : 32'h0);
    end
    edit = 4'b0000; step();
    chk("blink_stop", 32'(disp_blank), 32'h0);

    sel = 3'b100; step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_blank", 32'(disp_blank), 32'h0);
    chk("async_rst_active", 32'(active_ch), 32'h0);
    chk("async_rst_switch", 32'(switching), 32'h0);
    chk("async_rst_data", 32'(disp_data), 32'h0);
    sel = 3'b000;
    step();
    #2 rst = 1'b0;
    step();
    chk("post_rst_data", 32'(disp_data), 32'h1234);
    step();
    chk("post_rst_switch", 32'(switching), 32'h0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if ($urandom_range(5) == 0) sel = 3'($urandom);
      if ($urandom_range(9) == 0) edit = $urandom_range(1) ? 4'($urandom) : 4'h0;
      if ($urandom_range(24) == 0) ovr_en = ~ovr_en;
      if ($urandom_range(15) == 0) ch_data = {16'($urandom), 32'($urandom)};
      ovr_data = 16'($urandom);
      if ($urandom_range(499) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
